y_seq_mult: RTL and testbench
=============================

Name: y_seq_mult

Overview:
- Iterative 32x32 unsigned shift-add multiplier producing a 64-bit product.
- Sits directly upstream of the 32-bit ripple adder.
  - Each cycle it drives the adder's a/b/cin operands.
  - It consumes the adder's z and cout to build the product one bit per cycle.
- Intended as the datapath multiply unit next to the ALU. Uses valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32, operand width. Must equal the adder width (32); any other value is an elaboration error.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a/b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  a*b, unsigned

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (rst_n).
  - While rst_n=0: state=IDLE, in_ready=1, out_valid=0, product=0, counter=0, internal registers=0.
  - These take effect immediately, without waiting for a clock edge.
  - Deassertion is synchronised externally.
- States: IDLE, RUN, DONE. Encodings live in the shared package.
- IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1:
    - latch M<=a;
    - P<={WIDTH'b0, b}, where P is the 2*WIDTH shift register;
    - cnt<=0;
    - go to RUN.
  - The accepting edge is edge T.
- RUN:
  - in_ready=0, out_valid=0.
  - The adder is driven with a=P[2W-1:W], b=(P[0] ? M : 0), cin=0.
  - On each edge: P<={cout_eff, sum_eff, P[W-1:1]}.
    - sum_eff=z and cout_eff=cout if P[0]=1.
    - Otherwise sum_eff=P[2W-1:W] and cout_eff=0. The adder output with b=0 is identical, so the mux is optional.
  - cnt increments on each RUN edge.
  - On the edge where cnt==WIDTH-1: perform the last iteration and go to DONE.
- Latency:
  - Exactly WIDTH RUN edges. out_valid rises after edge T+WIDTH (T+32).
  - There is no early exit.
- DONE:
  - out_valid=1, product=P, held stable until the handshake.
  - On an edge with out_ready=1: go to IDLE, out_valid<=0.
  - in_ready stays 0 in DONE; there is no same-cycle pass-through.
  - The next operand pair is accepted at the earliest on the edge after returning to IDLE.
- product is a registered output. It keeps the last result in IDLE until the next accept; it is driven from P only in DONE, else holds.
- in_valid/a/b are ignored outside IDLE.
- out_ready is ignored outside DONE.
- Counter width is $clog2(WIDTH)+1 bits. The counter does not wrap within a run.
- The adder carry out must feed bit 2W-1 of the shifted P. Dropping it corrupts products with a high bit set.
- Reset mid-RUN or mid-DONE aborts the operation:
  - no partial result is presented;
  - after release, the block is in IDLE with in_ready=1.
- Simultaneous in_valid and out_ready in DONE: only the output handshake completes.

Decomposition:
- Shared package y_mult_pkg:
  - state typedef/localparams S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2;
  - MULT_W=32;
  - CNT_W.
- One sub-module: the existing 32-bit ripple adder (yAdder), instantiated once.
- Control FSM and P/M/cnt registers live in y_seq_mult.

Test Plan:
- a=3, b=5, in_valid for one cycle, out_ready=1 -> out_valid rises after edge T+32; product=64'd15 for one cycle; in_ready=1 the cycle after.
- a=32'hFFFFFFFF, b=32'hFFFFFFFF -> product=64'hFFFFFFFE_00000001. This exercises carry-out into the top bit.
- a=0, b=32'h1234 and a=32'h80000000, b=2 -> products 64'd0 and 64'h1_00000000.
- Backpressure with out_ready=0 for 10 cycles after out_valid -> product/out_valid stable, in_ready=0, and a new in_valid is ignored. Then raise out_ready -> one transfer, IDLE next.
- rst_n pulsed low mid-RUN (cnt=10) between edges -> out_valid=0 and in_ready=1 immediately. After release, a=7, b=6 yields product=42 at T+32.
- Back-to-back random pairs (1000 iterations) against a reference a*b -> every product matches. Each operation spans 34 cycles including the handshakes.

Source files
------------

// File: rtl/y_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding,
// operand width and iteration counter width.
package y_mult_pkg;

    localparam int MULT_W = 32;
    localparam int CNT_W  = $clog2(MULT_W) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/yAdder.sv
// 32-bit ripple-carry adder: z = a + b + cin, carry out of the top bit on cout.
module yAdder
    import y_mult_pkg::*;
(
    input  logic [MULT_W-1:0] a,
    input  logic [MULT_W-1:0] b,
    input  logic              cin,
    output logic [MULT_W-1:0] z,
    output logic              cout
);

    logic [MULT_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < MULT_W; i++) begin : g_fa
        assign z[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[MULT_W];

endmodule

// File: rtl/y_seq_mult.sv
// Iterative unsigned multiplier: one shift-add step per cycle through the
// ripple adder, WIDTH steps per operation, valid/ready on both sides.
module y_seq_mult
    import y_mult_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product
);

    if (WIDTH != MULT_W) begin : g_width_chk
        $error("y_seq_mult: WIDTH must equal the adder width");
    end

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     m_q, m_d;
    logic [2*WIDTH-1:0]   p_q, p_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH-1:0]     add_b;
    logic [WIDTH-1:0]     add_z;
    logic                 add_cout;
    logic [2*WIDTH-1:0]   p_step;

    // With b forced to zero the adder just passes the upper half through,
    // so its output is usable unconditionally.
    assign add_b = p_q[0] ? m_q : '0;

    yAdder u_add (
        .a    (p_q[2*WIDTH-1:WIDTH]),
        .b    (add_b),
        .cin  (1'b0),
        .z    (add_z),
        .cout (add_cout)
    );

    assign p_step = {add_cout, add_z, p_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        p_d       = p_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    m_d     = a;
                    p_d     = {{WIDTH{1'b0}}, b};
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                p_d   = p_step;
                cnt_d = cnt_q + CNT_W'(1);
                // Product register loads on the final step so it is valid
                // in the same cycle out_valid rises.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    product_d = p_step;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                product_d = p_q;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            p_q       <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Handshake flags decode straight from state so reset clears them at once.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_y_seq_mult.sv
// Self-checking bench for y_seq_mult: directed corner cases plus random
// back-to-back operations checked against a plain a*b reference.
module tb_y_seq_mult;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;

    int n_chk;
    int n_fail;

    y_seq_mult #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] xx;
        logic [63:0] yy;
        xx = {32'd0, x};
        yy = {32'd0, y};
        return xx * yy;
    endfunction

    // Present one operand pair, return edges from accept until out_valid.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
        a        = av;
        b        = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic op_check(input string tag, input logic [31:0] av, input logic [31:0] bv);
        int lat;
        run_op(av, bv, lat);
        chk({tag, "_latency"}, 64'(lat), 64'd32);
        chk({tag, "_product"}, product, ref_mul(av, bv));
    endtask

    // Complete the output handshake with out_ready already high.
    task automatic drain(input string tag);
        @(posedge clk);
        #1;
        chk({tag, "_out_valid_low"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_in_ready_high"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic [63:0] held;
        logic [31:0] ra;
        logic [31:0] rb;
        int          lat;

        n_chk     = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_product", product, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        op_check("3x5", 32'd3, 32'd5);
        drain("3x5");
        op_check("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("ffxff_const", product, 64'hFFFF_FFFE_0000_0001);
        drain("ffxff");
        op_check("0x1234", 32'd0, 32'h1234);
        drain("0x1234");
        op_check("msbx2", 32'h8000_0000, 32'd2);
        chk("msbx2_const", product, 64'h1_0000_0000);
        drain("msbx2");

        // Backpressure: product must hold, new operands ignored.
        out_ready = 1'b0;
        run_op(32'hDEAD_BEEF, 32'h1357_9BDF, lat);
        held = ref_mul(32'hDEAD_BEEF, 32'h1357_9BDF);
        chk("bp_latency", 64'(lat), 64'd32);
        chk("bp_product", product, held);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a        = $urandom;
            b        = $urandom;
            @(posedge clk);
            #1;
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_hold", product, held);
        end
        @(negedge clk) out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_idle_product_kept", product, held);
        @(posedge clk);
        #1;
        chk("bp_no_accept", {63'd0, in_ready}, 64'd1);

        // Reset in the middle of a run.
        @(negedge clk);
        a        = 32'h1234_5678;
        b        = 32'h9ABC_DEF0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_product", product, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        op_check("7x6", 32'd7, 32'd6);
        chk("7x6_const", product, 64'd42);
        drain("7x6");

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 0) ra = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            op_check("rand", ra, rb);
            drain("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
